// File: rtl/instmem_boot_pkg.sv
// Shared types, default sizes and the boot image for the instruction memory.
package instmem_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_ADDR_W   = 8;
    localparam int DEF_DEPTH    = 256;
    localparam int DEF_BOOT_LEN = 39;

    typedef enum logic {
        ST_BOOT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Boot image: a recognisable tag plus the index and its complement.
    function automatic logic [31:0] boot_word(input logic [7:0] idx);
        return {16'hC0DE, idx, ~idx};
    endfunction

endpackage

// File: rtl/instmem_boot_if.sv
// Fetch/write/control bundle between a requester (master) and instmem_boot (slave).
interface instmem_boot_if
    import instmem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) ();

    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic [DATA_W-1:0] fetch_data;
    logic              fetch_valid;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              reload;
    logic              ready;
    logic              addr_fault;
    logic              parity_err;

    modport master (
        output fetch_req, fetch_addr, wr_en, wr_addr, wr_data, reload,
        input  fetch_data, fetch_valid, ready, addr_fault, parity_err
    );

    modport slave (
        input  fetch_req, fetch_addr, wr_en, wr_addr, wr_data, reload,
        output fetch_data, fetch_valid, ready, addr_fault, parity_err
    );

endinterface

// File: rtl/instmem_boot_ram.sv
// Storage for instmem_boot: one write port, one synchronous read-first read port.
// The array is never reset; only the read register is.
module instmem_ram #(
    parameter int W      = 32,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [W-1:0]      i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    input  logic              i_rclr,
    output logic [W-1:0]      o_rdata
);

    logic [W-1:0] r_mem [DEPTH];
    logic [W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // i_rclr loads zero so an out-of-range fetch returns a clean word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end else if (i_rclr) begin
            r_rdata <= '0;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/instmem_boot.sv
// Instruction memory that sweeps in its boot image after reset or reload, then serves fetches/writes.
// Define INSTMEM_PARITY_EN to store an even-parity bit per word and report mismatches on parity_err.
module instmem_boot
    import instmem_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int BOOT_LEN = DEF_BOOT_LEN
) (
    input  logic           clk,
    input  logic           reset,
    instmem_boot_if.slave  bus
);

`ifdef INSTMEM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_next;
    logic              r_fetch_valid;
    logic              r_addr_fault;

    logic              w_ready;
    logic              w_fetch_ok;
    logic              w_fetch_oob;
    logic              w_wr_oob;
    logic              w_ram_we;
    logic              w_ram_re;
    logic              w_ram_rclr;
    logic [ADDR_W-1:0] w_ram_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic [MEM_W-1:0]  w_wword;
    logic [MEM_W-1:0]  w_rword;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_BOOT;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        case (r_state)
            ST_BOOT: begin
                if (int'(r_ptr) == DEPTH - 1) begin
                    w_state_next = ST_READY;
                    w_ptr_next   = '0;
                end else begin
                    w_ptr_next = r_ptr + ADDR_W'(1);
                end
            end
            ST_READY: begin
                if (bus.reload) begin
                    w_state_next = ST_BOOT;
                    w_ptr_next   = '0;
                end
            end
            default: begin
                w_state_next = ST_BOOT;
                w_ptr_next   = '0;
            end
        endcase
    end

    // While booting the sweep owns the write port and user traffic is dropped.
    always_comb begin
        w_ready     = (r_state == ST_READY);
        w_fetch_oob = int'(bus.fetch_addr) >= DEPTH;
        w_wr_oob    = int'(bus.wr_addr) >= DEPTH;
        w_fetch_ok  = w_ready & bus.fetch_req;
        w_ram_re    = w_fetch_ok & ~w_fetch_oob;
        w_ram_rclr  = w_fetch_ok & w_fetch_oob;
        w_ram_we    = 1'b0;
        w_ram_waddr = r_ptr;
        w_wdata     = '0;
        if (r_state == ST_BOOT) begin
            w_ram_we = 1'b1;
            if (int'(r_ptr) < BOOT_LEN) begin
                w_wdata = DATA_W'(boot_word(8'(r_ptr)));
            end
        end else begin
            w_ram_we    = bus.wr_en & ~w_wr_oob;
            w_ram_waddr = bus.wr_addr;
            w_wdata     = bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_valid <= 1'b0;
            r_addr_fault  <= 1'b0;
        end else begin
            r_fetch_valid <= w_fetch_ok;
            r_addr_fault  <= w_ready & ((bus.fetch_req & w_fetch_oob) | (bus.wr_en & w_wr_oob));
        end
    end

    instmem_ram #(
        .W      (MEM_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_ram_we),
        .i_waddr (w_ram_waddr),
        .i_wdata (w_wword),
        .i_re    (w_ram_re),
        .i_raddr (bus.fetch_addr),
        .i_rclr  (w_ram_rclr),
        .o_rdata (w_rword)
    );

`ifdef INSTMEM_PARITY_EN
    logic r_par_chk;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_par_chk <= 1'b0;
        end else begin
            r_par_chk <= w_ram_re;
        end
    end

    assign w_wword        = {^w_wdata, w_wdata};
    assign bus.fetch_data = w_rword[DATA_W-1:0];
    assign bus.parity_err = r_par_chk & (^w_rword);
`else
    assign w_wword        = w_wdata;
    assign bus.fetch_data = w_rword;
    assign bus.parity_err = 1'b0;
`endif

    assign bus.ready       = w_ready;
    assign bus.fetch_valid = r_fetch_valid;
    assign bus.addr_fault  = r_addr_fault;

endmodule
